wb_commit: RTL and testbench

- Parametrised write-back/commit stage; successor to the combinational write-back mux.
- Accepts one W-stage bundle per cycle over a valid/ready handshake.
- Aligns and extends load data, selects the GPR writeback value, and registers the GPR and CSR write requests.
- Counts retired instructions and runs a halt FSM on the halt instruction, replacing the combinational ebreak trap.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_commit_if.sv | 36 +++
 rtl/wb_load_align.sv | 44 ++++
 rtl/wb_commit.sv | 103 ++++++++++
 tb/tb_wb_commit.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back/commit stage.
// Holds valD select codes, load funct3 codes, FSM states and the halt encoding.
package wb_pkg;

    localparam logic [1:0] VALD_E    = 2'b00;
    localparam logic [1:0] VALD_P    = 2'b01;
    localparam logic [1:0] VALD_M    = 2'b10;
    localparam logic [1:0] VALD_ZERO = 2'b11;

    localparam logic [2:0] FN_LB  = 3'b000;
    localparam logic [2:0] FN_LH  = 3'b001;
    localparam logic [2:0] FN_LW  = 3'b010;
    localparam logic [2:0] FN_LD  = 3'b011;
    localparam logic [2:0] FN_LBU = 3'b100;
    localparam logic [2:0] FN_LHU = 3'b101;
    localparam logic [2:0] FN_LWU = 3'b110;
    localparam logic [2:0] FN_RAW = 3'b111;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [31:0] HALT_INSTR_DEF = 32'h00100073;

endpackage

// File: rtl/wb_commit_if.sv
// W-stage bundle handshake into the commit stage.
// master drives valid + bundle fields, slave returns ready.
interface wb_commit_if #(
    parameter int XLEN = 32
);
    localparam int AW = $clog2(XLEN / 8);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_valE;
    logic [XLEN-1:0] in_valM;
    logic [AW-1:0]   in_addr_lo;
    logic [2:0]      in_load_fn;
    logic [1:0]      in_valD_sel;
    logic            in_reg_wen;
    logic [4:0]      in_rd;
    logic [11:0]     in_csr_rd;
    logic [2:0]      in_csr_sel;

    modport master (
        output in_valid, in_pc, in_instr, in_valE, in_valM,
        output in_addr_lo, in_load_fn, in_valD_sel,
        output in_reg_wen, in_rd, in_csr_rd, in_csr_sel,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_valE, in_valM,
        input  in_addr_lo, in_load_fn, in_valD_sel,
        input  in_reg_wen, in_rd, in_csr_rd, in_csr_sel,
        output in_ready
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the lane at addr_lo and extends it.
// Ports: raw (memory word), addr_lo (byte offset), fn (funct3) -> data.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] raw,
    input  logic [AW-1:0]   addr_lo,
    input  logic [2:0]      fn,
    output logic [XLEN-1:0] data
);

    // Halves and words ignore offset bits below their own granularity.
    localparam logic [AW-1:0] HMASK = ~AW'(1);
    localparam logic [AW-1:0] WMASK = ~AW'(3);

    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    logic [XLEN-1:0] w_s;

    assign b   = 8'(raw >> {addr_lo, 3'b000});
    assign h   = 16'(raw >> {addr_lo & HMASK, 3'b000});
    assign w   = 32'(raw >> {addr_lo & WMASK, 3'b000});
    assign w_s = XLEN'($signed(w));

    always_comb begin
        data = raw;
        unique case (fn)
            FN_LB:  data = XLEN'($signed(b));
            FN_LH:  data = XLEN'($signed(h));
            FN_LW:  data = w_s;
            FN_LD:  data = (XLEN == 64) ? raw : w_s;
            FN_LBU: data = XLEN'(b);
            FN_LHU: data = XLEN'(h);
            FN_LWU: data = XLEN'(w);
            FN_RAW: data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/wb_commit.sv
// Write-back/commit stage: aligns loads, registers GPR/CSR writes,
// counts retirements and halts on HALT_INSTR. Ports: clk, rst, bus, out_*.
module wb_commit
    import wb_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          CNT_W      = 64,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    wb_commit_if.slave       bus,
    output logic             out_reg_wen,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_valD,
    output logic             out_csr_wen,
    output logic [11:0]      out_csr_rd,
    output logic [2:0]       out_csr_sel,
    output logic             out_retire,
    output logic [XLEN-1:0]  out_retire_pc,
    output logic [CNT_W-1:0] out_instret,
    output logic             out_halted,
    output logic [XLEN-1:0]  out_halt_pc
);

    localparam int AW = $clog2(XLEN / 8);

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            is_halt;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] valD;

    wb_load_align #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_align (
        .raw     (bus.in_valM),
        .addr_lo (bus.in_addr_lo),
        .fn      (bus.in_load_fn),
        .data    (load_data)
    );

    assign bus.in_ready = (state_q == RUN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_halt      = (bus.in_instr == HALT_INSTR);
    assign out_halted   = (state_q == HALTED);

    always_comb begin
        valD = '0;
        unique case (bus.in_valD_sel)
            VALD_E:    valD = bus.in_valE;
            VALD_P:    valD = bus.in_pc + XLEN'(4);
            VALD_M:    valD = load_data;
            VALD_ZERO: valD = '0;
            default:   valD = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // HALTED is sticky; only reset leaves it.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && accept && is_halt)
            state_d = HALTED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg_wen   <= 1'b0;
            out_rd        <= '0;
            out_valD      <= '0;
            out_csr_wen   <= 1'b0;
            out_csr_rd    <= '0;
            out_csr_sel   <= '0;
            out_retire    <= 1'b0;
            out_retire_pc <= '0;
            out_instret   <= '0;
            out_halt_pc   <= '0;
        end else begin
            out_reg_wen <= accept && bus.in_reg_wen &&
                           (bus.in_rd != 5'd0) && !is_halt;
            out_csr_wen <= accept && (bus.in_csr_sel != 3'd0) && !is_halt;
            out_retire  <= accept;
            if (accept) begin
                out_rd        <= bus.in_rd;
                out_valD      <= valD;
                out_csr_rd    <= bus.in_csr_rd;
                out_csr_sel   <= bus.in_csr_sel;
                out_retire_pc <= bus.in_pc;
                out_instret   <= out_instret + CNT_W'(1);
                if (is_halt)
                    out_halt_pc <= bus.in_pc;
            end
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit (XLEN=32).
// Bundles push expected commits; a negedge monitor pops and compares.
module tb_wb_commit;

    localparam logic [31:0] HALT = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    typedef struct {
        logic        reg_wen;
        logic [4:0]  rd;
        logic [31:0] valD;
        logic        csr_wen;
        logic [2:0]  csr_sel;
        logic [11:0] csr_rd;
        logic [31:0] pc;
        logic [63:0] cnt;
        logic        halted;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        out_reg_wen;
    logic [4:0]  out_rd;
    logic [31:0] out_valD;
    logic        out_csr_wen;
    logic [11:0] out_csr_rd;
    logic [2:0]  out_csr_sel;
    logic        out_retire;
    logic [31:0] out_retire_pc;
    logic [63:0] out_instret;
    logic        out_halted;
    logic [31:0] out_halt_pc;

    int          n_chk;
    int          n_err;
    int          n_ret;
    logic [63:0] cnt;
    exp_t        q[$];

    wb_commit_if #(.XLEN(32)) bus ();

    wb_commit #(.XLEN(32), .CNT_W(64), .HALT_INSTR(HALT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .out_reg_wen   (out_reg_wen),
        .out_rd        (out_rd),
        .out_valD      (out_valD),
        .out_csr_wen   (out_csr_wen),
        .out_csr_rd    (out_csr_rd),
        .out_csr_sel   (out_csr_sel),
        .out_retire    (out_retire),
        .out_retire_pc (out_retire_pc),
        .out_instret   (out_instret),
        .out_halted    (out_halted),
        .out_halt_pc   (out_halt_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_retire) begin
                n_ret++;
                if (q.size() == 0) begin
                    chk("spurious_retire", 64'(out_retire), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("reg_wen", 64'(out_reg_wen), 64'(e.reg_wen));
                    chk("rd", 64'(out_rd), 64'(e.rd));
                    chk("valD", 64'(out_valD), 64'(e.valD));
                    chk("csr_wen", 64'(out_csr_wen), 64'(e.csr_wen));
                    chk("csr_sel", 64'(out_csr_sel), 64'(e.csr_sel));
                    chk("csr_rd", 64'(out_csr_rd), 64'(e.csr_rd));
                    chk("retire_pc", 64'(out_retire_pc), 64'(e.pc));
                    chk("instret", out_instret, e.cnt);
                    chk("halted", 64'(out_halted), 64'(e.halted));
                end
            end else begin
                chk("idle_pulse", 64'({out_reg_wen, out_csr_wen}), 64'd0);
            end
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] valE, input logic [31:0] valM,
                        input logic [1:0] alo, input logic [2:0] fn,
                        input logic [1:0] sel, input logic wen,
                        input logic [4:0] rd, input logic [2:0] csr_sel,
                        input logic [11:0] csr_rd,
                        input logic [31:0] exp_valD);
        logic acc;
        exp_t e;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_pc       = pc;
        bus.in_instr    = instr;
        bus.in_valE     = valE;
        bus.in_valM     = valM;
        bus.in_addr_lo  = alo;
        bus.in_load_fn  = fn;
        bus.in_valD_sel = sel;
        bus.in_reg_wen  = wen;
        bus.in_rd       = rd;
        bus.in_csr_sel  = csr_sel;
        bus.in_csr_rd   = csr_rd;
        acc = bus.in_ready;
        @(posedge clk);
        if (acc) begin
            cnt       = cnt + 64'd1;
            e.reg_wen = wen && (rd != 5'd0) && (instr != HALT);
            e.rd      = rd;
            e.valD    = exp_valD;
            e.csr_wen = (csr_sel != 3'd0) && (instr != HALT);
            e.csr_sel = csr_sel;
            e.csr_rd  = csr_rd;
            e.pc      = pc;
            e.cnt     = cnt;
            e.halted  = (instr == HALT);
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_retire"}, 64'(out_retire), 64'd0);
        chk({tag, "_valD"}, 64'(out_valD), 64'd0);
        chk({tag, "_instret"}, out_instret, 64'd0);
        chk({tag, "_halted"}, 64'(out_halted), 64'd0);
        chk({tag, "_halt_pc"}, 64'(out_halt_pc), 64'd0);
        chk({tag, "_rd"}, 64'(out_rd), 64'd0);
    endtask

    initial begin
        int base;
        n_chk = 0;
        n_err = 0;
        n_ret = 0;
        cnt   = '0;
        rst   = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_pc       = '0;
        bus.in_instr    = '0;
        bus.in_valE     = '0;
        bus.in_valM     = '0;
        bus.in_addr_lo  = '0;
        bus.in_load_fn  = '0;
        bus.in_valD_sel = '0;
        bus.in_reg_wen  = 1'b0;
        bus.in_rd       = '0;
        bus.in_csr_sel  = '0;
        bus.in_csr_rd   = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;

        send(32'h100, NOP, 32'h1234, 0, 0, 0, 2'b00, 1, 5, 0, 0, 32'h1234);
        send(32'h104, NOP, 32'h1234, 0, 0, 0, 2'b00, 1, 0, 0, 0, 32'h1234);
        idle(1);
        send(32'h108, NOP, 0, 32'h80FF7F01, 3, 3'b000, 2'b10, 1, 1, 0, 0,
             32'hFFFFFF80);
        send(32'h10C, NOP, 0, 32'h80FF7F01, 1, 3'b100, 2'b10, 1, 2, 0, 0,
             32'h0000007F);
        send(32'h110, NOP, 0, 32'h80FF7F01, 2, 3'b001, 2'b10, 1, 3, 0, 0,
             32'hFFFF80FF);
        send(32'h114, NOP, 0, 32'h80FF7F01, 3, 3'b101, 2'b10, 1, 4, 0, 0,
             32'h000080FF);
        send(32'h118, NOP, 0, 32'h80FF7F01, 1, 3'b010, 2'b10, 1, 6, 0, 0,
             32'h80FF7F01);
        send(32'h11C, NOP, 0, 32'h80FF7F01, 2, 3'b111, 2'b10, 1, 6, 0, 0,
             32'h80FF7F01);
        send(32'hFFFFFFFC, NOP, 0, 0, 0, 0, 2'b01, 1, 8, 0, 0, 32'h0);
        send(32'h200, NOP, 32'hDEAD, 0, 0, 0, 2'b01, 1, 9, 0, 0, 32'h204);
        send(32'h208, NOP, 32'hBEEF, 0, 0, 0, 2'b11, 1, 10, 2, 12'h300,
             32'h0);
        idle(2);

        base = n_ret;
        for (int i = 0; i < 10; i++)
            send(32'h1000 + 32'(4 * i), NOP, 32'(i * 3), 0, 0, 0, 2'b00, 1,
                 5'(i + 1), 0, 0, 32'(i * 3));
        idle(2);
        chk("burst_retires", 64'(n_ret - base), 64'd10);

        send(32'h80000010, HALT, 32'h55, 0, 0, 0, 2'b00, 1, 7, 1, 12'h305,
             32'h55);
        @(negedge clk);
        #1;
        chk("halt_pc", 64'(out_halt_pc), 64'h80000010);
        chk("halt_ready", 64'(bus.in_ready), 64'd0);
        base = n_ret;
        for (int i = 0; i < 3; i++)
            send(32'h300, NOP, 32'h77, 0, 0, 0, 2'b00, 1, 3, 1, 0, 32'h77);
        idle(2);
        chk("halted_no_retire", 64'(n_ret - base), 64'd0);
        chk("halted_stays", 64'(out_halted), 64'd1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("rst_halted");
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        cnt = '0;
        @(negedge clk);
        rst = 1'b0;

        send(32'h400, NOP, 32'hA1, 0, 0, 0, 2'b00, 1, 11, 0, 0, 32'hA1);
        send(32'h404, NOP, 32'hA2, 0, 0, 0, 2'b00, 1, 12, 0, 0, 32'hA2);
        send(32'h408, NOP, 32'hA3, 0, 0, 0, 2'b00, 1, 13, 0, 0, 32'hA3);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        bus.in_valid = 1'b0;
        q.delete();
        cnt = '0;
        @(negedge clk);
        rst = 1'b0;

        send(32'h500, NOP, 32'hB1, 0, 0, 0, 2'b00, 1, 14, 0, 0, 32'hB1);
        idle(3);
        chk("sb_drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 exp 0");
        $fatal(1);
    end

endmodule
